// File: rtl/cp0_exc_ctrl_if.sv
// Signal bundle between the MEM stage / CP0 register file and the exception sequencer.
// The slave modport is the sequencer; the master modport is the pipeline and CP0 side.
interface cp0_exc_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        instr_bd;
    logic        is_syscall;
    logic        is_eret;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic        cp0_we;
    logic [5:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport slave (
        input  instr_valid, instr_pc, instr_bd, is_syscall, is_eret,
        input  status, cause, epc, ebase,
        output cp0_we, cp0_waddr, cp0_wdata, flush, busy, redirect_valid, redirect_pc
    );

    modport master (
        output instr_valid, instr_pc, instr_bd, is_syscall, is_eret,
        output status, cause, epc, ebase,
        input  cp0_we, cp0_waddr, cp0_wdata, flush, busy, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET sequencer: flushes the pipeline, writes EPC/Cause/Status
// through the single CP0 write port and redirects fetch. All outputs are registered.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_OFFSET = 32'h00000180,
    parameter logic [4:0]  INT_CODE   = 5'b00000,
    parameter logic [4:0]  SYS_CODE   = 5'b01000
) (
    input  logic          clk,
    input  logic          rst,
    cp0_exc_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, WR_EPC, WR_CAUSE, WR_STATUS, ERET_STATUS, REDIRECT
    } state_e;

    localparam logic [5:0] ADDR_STATUS = 6'd12;
    localparam logic [5:0] ADDR_CAUSE  = 6'd13;
    localparam logic [5:0] ADDR_EPC    = 6'd14;

    state_e      state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] ebase_q, ebase_d;

    logic        we_q, we_d;
    logic [5:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        flush_q, flush_d;
    logic        busy_q, busy_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;

    logic        int_pending;

    // Evaluated on the live Status, so EXL set by our own write masks further interrupts.
    assign int_pending = bus.status[0] & ~bus.status[1] &
                         (|(bus.status[15:10] & bus.cause[15:10]));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        pc_d     = pc_q;
        bd_d     = bd_q;
        code_d   = code_q;
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        ebase_d  = ebase_q;
        we_d     = 1'b0;
        waddr_d  = '0;
        wdata_d  = '0;
        flush_d  = 1'b0;
        busy_d   = 1'b0;
        rv_d     = 1'b0;
        rpc_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid && (int_pending || bus.is_syscall || bus.is_eret)) begin
                    pc_d     = bus.instr_pc;
                    bd_d     = bus.instr_bd;
                    status_d = bus.status;
                    cause_d  = bus.cause;
                    epc_d    = bus.epc;
                    ebase_d  = bus.ebase;
                    if (int_pending) begin
                        code_d  = INT_CODE;
                        state_d = WR_EPC;
                    end else if (bus.is_syscall) begin
                        code_d  = SYS_CODE;
                        state_d = WR_EPC;
                    end else begin
                        state_d = ERET_STATUS;
                    end
                end
            end
            WR_EPC:      state_d = WR_CAUSE;
            WR_CAUSE:    state_d = WR_STATUS;
            WR_STATUS:   state_d = REDIRECT;
            ERET_STATUS: state_d = REDIRECT;
            REDIRECT:    state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        // Outputs are derived from the state being entered, then registered.
        busy_d = (state_d != IDLE);
        unique case (state_d)
            WR_EPC: begin
                flush_d = 1'b1;
                we_d    = 1'b1;
                waddr_d = ADDR_EPC;
                wdata_d = bd_d ? (pc_d - 32'd4) : pc_d;
            end
            WR_CAUSE: begin
                we_d    = 1'b1;
                waddr_d = ADDR_CAUSE;
                wdata_d = {bd_d, cause_d[30:7], code_d, cause_d[1:0]};
            end
            WR_STATUS: begin
                we_d    = 1'b1;
                waddr_d = ADDR_STATUS;
                wdata_d = status_d | 32'h2;
            end
            ERET_STATUS: begin
                flush_d = 1'b1;
                we_d    = 1'b1;
                waddr_d = ADDR_STATUS;
                wdata_d = status_d & ~32'h2;
            end
            REDIRECT: begin
                rv_d  = 1'b1;
                rpc_d = (state_q == ERET_STATUS) ? epc_d : (ebase_d + EXC_OFFSET);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            bd_q     <= 1'b0;
            code_q   <= '0;
            status_q <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
            ebase_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            bd_q     <= bd_d;
            code_q   <= code_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            ebase_q  <= ebase_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            flush_q  <= flush_d;
            busy_q   <= busy_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
        end
    end

    assign bus.cp0_we         = we_q;
    assign bus.cp0_waddr      = waddr_q;
    assign bus.cp0_wdata      = wdata_q;
    assign bus.flush          = flush_q;
    assign bus.busy           = busy_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception/interrupt sequencer that drives the CP0 register file's single write port and consumes its ebase/status/cause/epc outputs. It sits beside the MEM stage. On a hardware interrupt or SYSCALL it flushes the pipeline, saves EPC, updates Cause and then sets Status.EXL over successive cycles, and redirects fetch to the exception vector. On ERET it clears EXL and redirects fetch to EPC.

Parameters:
EXC_OFFSET, 32'h00000180, offset added to ebase to form the exception vector
INT_CODE, 5'b00000, ExcCode written for an interrupt
SYS_CODE, 5'b01000, ExcCode written for SYSCALL

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
instr_valid  in  1  MEM-stage instruction valid
instr_pc  in  32  PC of the MEM-stage instruction
instr_bd  in  1  MEM-stage instruction is in a delay slot
is_syscall  in  1  MEM-stage instruction is SYSCALL
is_eret  in  1  MEM-stage instruction is ERET
status  in  32  CP0 Status
cause  in  32  CP0 Cause
epc  in  32  CP0 EPC
ebase  in  32  CP0 EBase
cp0_we  out  1  CP0 write enable
cp0_waddr  out  6  CP0 write address (12=status, 13=cause, 14=epc)
cp0_wdata  out  32  CP0 write data
flush  out  1  one-cycle pipeline flush pulse
busy  out  1  stall the pipeline; asserted whenever state != IDLE
redirect_valid  out  1  one-cycle fetch redirect strobe
redirect_pc  out  32  redirect target

Behaviour:
- States: IDLE, WR_EPC, WR_CAUSE, WR_STATUS, ERET_STATUS, REDIRECT. All outputs are registered (Moore on the next state).
- Reset: state=IDLE; cp0_we=0, cp0_waddr=0, cp0_wdata=0, flush=0, busy=0, redirect_valid=0, redirect_pc=0; all snapshot registers cleared.
- int_pending = status[0] & ~status[1] & |(status[15:10] & cause[15:10]).
- Triggers are sampled only in IDLE, in priority order:
  1. int_pending & instr_valid: code=INT_CODE.
  2. instr_valid & is_syscall: code=SYS_CODE.
  3. instr_valid & is_eret: ERET path.
- Snapshot on trigger: instr_pc, instr_bd, code, status, cause, epc, ebase.
- Exception path, trigger at edge T:
  - Cycle T+1, WR_EPC: flush=1, busy=1, we=1, waddr=14, wdata = bd ? pc-4 : pc (mod 2^32).
  - Cycle T+2, WR_CAUSE: we=1, waddr=13, wdata = {bd, cause_s[30:7], code, cause_s[1:0]}.
  - Cycle T+3, WR_STATUS: we=1, waddr=12, wdata = status_s | 32'h2.
  - Cycle T+4, REDIRECT: we=0, redirect_valid=1, redirect_pc = ebase_s + EXC_OFFSET (mod 2^32).
  - Cycle T+5: IDLE, busy=0.
- ERET path, trigger at edge T:
  - Cycle T+1, ERET_STATUS: flush=1, busy=1, we=1, waddr=12, wdata = status_s & ~32'h2.
  - Cycle T+2, REDIRECT: redirect_pc = epc_s.
  - Cycle T+3: IDLE.
- flush and redirect_valid are high for exactly one cycle per event. cp0_we is never high in IDLE or REDIRECT.
- All inputs are ignored while busy. A new event is accepted in the first IDLE cycle after REDIRECT.
- Simultaneous is_syscall and is_eret: syscall wins. An interrupt pending with instr_valid=0 is not taken; it is held until a valid instruction reaches MEM.
- Interrupts are masked while EXL=1. This includes the cycles after WR_STATUS, because the mask is evaluated on the live status input.
- Reset mid-sequence: the FSM returns to IDLE at once and no further CP0 writes or redirect are issued. Writes already performed are not undone.
- When a write is not active, cp0_waddr and cp0_wdata hold 0.

Test Plan:
- Reset, then idle inputs -> every output stays 0 for 10 cycles.
- SYSCALL: pc=0x00400020, bd=0, ebase=0x80000000, status=0x00001001 -> epc write 0x00400020, cause write with [6:2]=01000 and [31]=0, status write 0x00001003, redirect 0x80000180. Sequence spans T+1..T+4, flush only at T+1.
- Interrupt in delay slot: status=0x00001001, cause[12]=1, pc=0x00400044, bd=1 -> epc write 0x00400040, cause [31]=1 and [6:2]=00000. Same interrupt with status=0x00001003 -> no event.
- ERET: epc=0x00400048, status=0x00001003 -> status write 0x00001001 at T+1, redirect 0x00400048 at T+2, busy low at T+3.
- Back-to-back: is_syscall held high throughout, with a toggling is_eret -> second syscall accepted only after return to IDLE. No overlap; the syscall/eret tie resolves to syscall.
- rst asserted during WR_CAUSE -> next cycle all outputs 0, no WR_STATUS and no redirect.
